// File: rtl/jtbubl_scan2x.sv
// Line-doubling scan converter: writes one bank of a two-bank line buffer at pxl_cen
// while the other bank is read out twice at pxl2_cen; en=0 passes the native stream through.
module jtbubl_scan2x #(
    parameter int unsigned HW       = 256,
    parameter int unsigned HLEN     = 384,
    parameter int unsigned HS_START = 288,
    parameter int unsigned HS_LEN   = 28,
    parameter int unsigned CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          pxl2_cen,
    input  logic          en,
    input  logic [CW-1:0] red_in,
    input  logic [CW-1:0] green_in,
    input  logic [CW-1:0] blue_in,
    input  logic          LHBL_in,
    input  logic          LVBL_in,
    input  logic          HS_in,
    input  logic          VS_in,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          LHBL_out,
    output logic          LVBL_out,
    output logic          HS_out,
    output logic          VS_out
);

    localparam int unsigned AW  = $clog2(HW);
    localparam int unsigned HCW = $clog2(HLEN);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pixel_t;

    pixel_t          mem [2*HW];
    logic            wbank;
    logic            rbank;
    logic            synced;
    logic            lhbl_last;
    logic [AW-1:0]   wr_addr;
    logic [HCW-1:0]  hcnt;

    logic            eol;
    logic            visible;
    logic            hs_win;
    pixel_t          in_pix;
    pixel_t          rd_pix;

    assign eol     = pxl_cen & lhbl_last & ~LHBL_in;
    assign in_pix  = {red_in, green_in, blue_in};
    assign rd_pix  = mem[{rbank, hcnt[AW-1:0]}];
    assign visible = synced && (hcnt < HCW'(HW));
    assign hs_win  = synced && (hcnt >= HCW'(HS_START)) && (hcnt < HCW'(HS_START + HS_LEN));

    // Line buffer write port; RAM content is deliberately not reset.
    always_ff @(posedge clk) begin
        if (pxl_cen && LHBL_in) begin
            mem[{wbank, wr_addr}] <= in_pix;
        end
    end

    // Bank swap, write address and output line counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank     <= 1'b0;
            rbank     <= 1'b1;
            wr_addr   <= '0;
            hcnt      <= '0;
            synced    <= 1'b0;
            lhbl_last <= 1'b0;
        end else begin
            if (pxl_cen) begin
                lhbl_last <= LHBL_in;
                if (eol) begin
                    rbank   <= wbank;
                    wbank   <= ~wbank;
                    wr_addr <= '0;
                    synced  <= 1'b1;
                end else if (LHBL_in && (wr_addr != AW'(HW - 1))) begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            // A new input line restarts the output line, overriding the wrap
            if (eol) begin
                hcnt <= '0;
            end else if (pxl2_cen) begin
                hcnt <= (hcnt == HCW'(HLEN - 1)) ? '0 : hcnt + 1'b1;
            end
        end
    end

    // Output registers: native copy in bypass, doubled stream otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            LHBL_out <= 1'b0;
            LVBL_out <= 1'b0;
            HS_out   <= 1'b0;
            VS_out   <= 1'b0;
        end else if (!en) begin
            red      <= red_in;
            green    <= green_in;
            blue     <= blue_in;
            LHBL_out <= LHBL_in;
            LVBL_out <= LVBL_in;
            HS_out   <= HS_in;
            VS_out   <= VS_in;
        end else begin
            if (pxl2_cen) begin
                red      <= visible ? rd_pix.r : '0;
                green    <= visible ? rd_pix.g : '0;
                blue     <= visible ? rd_pix.b : '0;
                LHBL_out <= visible;
                HS_out   <= hs_win;
            end
            if (eol) begin
                LVBL_out <= LVBL_in;
                VS_out   <= VS_in;
            end
        end
    end

endmodule
